syn_gpu_div_agent: RTL and testbench
====================================

// Module: syn_gpu_div_agent
// PURPOSE
//  Initiator end of the mulberry-bus divide channel. Accepts 16b/16b divide jobs from a local GPU
//  client over a valid/ready handshake. Issues each job on the mulberry bus div request lines, tagged
//  with the agent's own MID, then waits for the matching div response.
//  Returns quotient/remainder (or an error) to the client; one job is outstanding at a time.
// PARAMETERS
//  P_MID      MID_IDLE+1  own MID code driven on div_req_mid; must not equal MID_IDLE
//  P_TIMEOUT  64          max cycles in WAIT_RSP before the job is aborted with error
// PORTS
//  clk_ir         in   1      clock
//  rst_sync       in   1      reset, synchronous, active-high
//  req_valid      in   1      client job valid
//  req_ready      out  1      agent can accept job
//  req_dividend   in   16     dividend
//  req_divisor    in   16     divisor
//  rsp_valid      out  1      result valid, held until rsp_ready
//  rsp_ready      in   1      client accepts result
//  rsp_quotient   out  16     quotient
//  rsp_remainder  out  16     remainder
//  rsp_err        out  1      1 = timeout (or div-by-zero when the bypass is compiled in)
//  div_req_mid    out  mid_t  bus request MID; MID_IDLE = no request
//  div_req_data   out  32     [31:16] dividend, [15:0] divisor
//  div_busy       in   1      divider occupied
//  div_rsp_mid    in   mid_t  response MID, asserted for one cycle
//  div_rsp_data   in   32     [31:16] quotient, [15:0] remainder, valid when div_rsp_mid != MID_IDLE
// BEHAVIOUR
//  Reset values (rst_sync=1, sampled on clk_ir): state IDLE, req_ready=0, rsp_valid=0, rsp_err=0,
//   rsp_quotient=rsp_remainder=0, div_req_mid=MID_IDLE, div_req_data=0, timeout cnt=0.
//  FSM IDLE -> ISSUE -> WAIT_RSP -> DONE -> IDLE:
//   IDLE: req_ready=1 (combinational from state, not a function of req_valid).
//    On req_valid&req_ready, latch dividend/divisor and go to ISSUE.
//   ISSUE: if div_busy==0, drive div_req_mid=P_MID and div_req_data for exactly 1 cycle (registered),
//    then go to WAIT_RSP with cnt=0. If div_busy==1, keep div_req_mid=MID_IDLE and stay in ISSUE.
//   WAIT_RSP: div_req_mid=MID_IDLE, cnt++ each cycle.
//    If div_rsp_mid==P_MID: capture div_rsp_data, set err=0, go to DONE.
//    Else if cnt==P_TIMEOUT-1: set q=r=16'hFFFF, err=1, go to DONE.
//    A matching response has priority over the timeout in the same cycle.
//   DONE: rsp_valid=1 with outputs stable; on rsp_ready go to IDLE. rsp_ready while not DONE is ignored.
//  A div_rsp_mid != P_MID is ignored in every state. A div_rsp_mid == P_MID outside WAIT_RSP is
//   ignored (stale response after reset or timeout).
//  Latency with a free divider: accept in cycle N, request on bus in N+2, result depends on divider.
//   rsp_valid rises the cycle after the matching div_rsp_mid.
//  Back-to-back jobs: the earliest next req_ready is the cycle after rsp_ready handshakes.
//  Reset mid-operation: abandon the job immediately, no rsp_valid, bus request lines to MID_IDLE.
//  Widths: data passed through unsigned. The agent performs no arithmetic except the counter,
//   which is $clog2(P_TIMEOUT) bits and saturates.
// CONFIGURATION
//  SYN_GPU_DIV_ZERO_BYPASS_EN defined:
//   In ISSUE, if the latched divisor==0, the job is not put on the bus.
//   Next cycle go to DONE with q=16'hFFFF, r=dividend, err=1.
//  SYN_GPU_DIV_ZERO_BYPASS_EN undefined: divide-by-zero is issued on the bus like any other job.
// STRUCTURE
//  syn_gpu_pkg: mid_t, MID_IDLE, P_16B_W, plus a new typedef enum div_agent_state_t
//   {DIV_AGT_IDLE, DIV_AGT_ISSUE, DIV_AGT_WAIT_RSP, DIV_AGT_DONE}.
//  No sub-module: one FSM, one timeout counter, output registers.
// TESTING
//  1. 100/7, div_busy=0, divider model replies after 10 cycles -> one bus req (mid=P_MID,
//     data=0x0064_0007); rsp q=14, r=2, err=0.
//  2. div_busy=1 for 20 cycles at issue -> div_req_mid stays MID_IDLE until busy=0, then exactly one
//     1-cycle request; correct result returned.
//  3. Response tagged with a foreign MID in WAIT_RSP, then P_MID -> foreign one ignored, only the
//     P_MID data returned.
//  4. No response with P_TIMEOUT=64 -> rsp_valid 64 cycles after the request, q=r=0xFFFF, err=1.
//     A late P_MID response is then ignored.
//  5. 0x1234/0 -> with macro: no bus request, q=0xFFFF, r=0x1234, err=1.
//     Without macro: request issued, divider result passed through.
//  6. rst_sync asserted in WAIT_RSP, then response arrives -> no rsp_valid; all outputs at reset
//     values; next job completes normally.

Source files
------------

// File: rtl/syn_gpu_pkg.sv
// Shared mulberry-bus types for the GPU-side agents: MID encoding, data width
// and the divide-agent FSM state type.
package syn_gpu_pkg;

   typedef logic [3:0] mid_t;

   localparam mid_t MID_IDLE = 4'd0;
   localparam int   P_16B_W  = 16;

   typedef enum logic [1:0] {
      DIV_AGT_IDLE,
      DIV_AGT_ISSUE,
      DIV_AGT_WAIT_RSP,
      DIV_AGT_DONE
   } div_agent_state_t;

   // Request payload layout: dividend in the upper half, divisor in the lower half.
   function automatic logic [2*P_16B_W-1:0] pack_div_req(input logic [P_16B_W-1:0] dividend,
                                                         input logic [P_16B_W-1:0] divisor);
      return {dividend, divisor};
   endfunction

endpackage

// File: rtl/syn_gpu_div_agent.sv
// Initiator end of the mulberry-bus divide channel: one outstanding 16b/16b job, timeout-guarded.
// Define SYN_GPU_DIV_ZERO_BYPASS_EN to answer divide-by-zero locally instead of issuing it on the bus.
module syn_gpu_div_agent
   import syn_gpu_pkg::*;
#(
   parameter mid_t P_MID     = mid_t'(MID_IDLE + 4'd1),  // must differ from MID_IDLE
   parameter int   P_TIMEOUT = 64
) (
   input  logic                 clk_ir,
   input  logic                 rst_sync,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [P_16B_W-1:0]   req_dividend,
   input  logic [P_16B_W-1:0]   req_divisor,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [P_16B_W-1:0]   rsp_quotient,
   output logic [P_16B_W-1:0]   rsp_remainder,
   output logic                 rsp_err,
   output mid_t                 div_req_mid,
   output logic [2*P_16B_W-1:0] div_req_data,
   input  logic                 div_busy,
   input  mid_t                 div_rsp_mid,
   input  logic [2*P_16B_W-1:0] div_rsp_data
);

   localparam int               CNT_W    = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_TIMEOUT - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   div_agent_state_t     state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [P_16B_W-1:0]   dividend_q, dividend_d;
   logic [P_16B_W-1:0]   divisor_q, divisor_d;
   mid_t                 req_mid_q, req_mid_d;
   logic [2*P_16B_W-1:0] req_data_q, req_data_d;
   logic [P_16B_W-1:0]   quot_q, quot_d;
   logic [P_16B_W-1:0]   rem_q, rem_d;
   logic                 err_q, err_d;

   // Handshake flags are masked while reset is held so the client never sees a half-reset agent.
   assign req_ready     = (state_q == DIV_AGT_IDLE) && !rst_sync;
   assign rsp_valid     = (state_q == DIV_AGT_DONE) && !rst_sync;
   assign rsp_quotient  = quot_q;
   assign rsp_remainder = rem_q;
   assign rsp_err       = err_q;
   assign div_req_mid   = req_mid_q;
   assign div_req_data  = req_data_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      req_mid_d  = MID_IDLE;
      req_data_d = '0;
      quot_d     = quot_q;
      rem_d      = rem_q;
      err_d      = err_q;

      case (state_q)
         DIV_AGT_IDLE: begin
            if (req_valid) begin
               dividend_d = req_dividend;
               divisor_d  = req_divisor;
               state_d    = DIV_AGT_ISSUE;
            end
         end
         DIV_AGT_ISSUE: begin
`ifdef SYN_GPU_DIV_ZERO_BYPASS_EN
            if (divisor_q == '0) begin
               quot_d  = '1;
               rem_d   = dividend_q;
               err_d   = 1'b1;
               state_d = DIV_AGT_DONE;
            end else
`endif
            if (!div_busy) begin
               req_mid_d  = P_MID;
               req_data_d = pack_div_req(dividend_q, divisor_q);
               cnt_d      = '0;
               state_d    = DIV_AGT_WAIT_RSP;
            end
         end
         DIV_AGT_WAIT_RSP: begin
            cnt_d = sat_inc(cnt_q);
            // A matching response wins over a timeout landing in the same cycle.
            if (div_rsp_mid == P_MID) begin
               quot_d  = div_rsp_data[2*P_16B_W-1:P_16B_W];
               rem_d   = div_rsp_data[P_16B_W-1:0];
               err_d   = 1'b0;
               state_d = DIV_AGT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               quot_d  = '1;
               rem_d   = '1;
               err_d   = 1'b1;
               state_d = DIV_AGT_DONE;
            end
         end
         DIV_AGT_DONE: begin
            if (rsp_ready) begin
               state_d = DIV_AGT_IDLE;
            end
         end
         default: state_d = DIV_AGT_IDLE;
      endcase
   end

   always_ff @(posedge clk_ir) begin
      if (rst_sync) begin
         state_q    <= DIV_AGT_IDLE;
         cnt_q      <= '0;
         req_mid_q  <= MID_IDLE;
         req_data_q <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         req_mid_q  <= req_mid_d;
         req_data_q <= req_data_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         err_q      <= err_d;
      end
   end

   // Job operands are only consumed after a fresh accept, so they need no reset.
   always_ff @(posedge clk_ir) begin
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
   end

endmodule

// File: tb/tb_syn_gpu_div_agent.sv
// Directed/randomised bench for syn_gpu_div_agent with a behavioural divider peer on the bus side.
// Honours SYN_GPU_DIV_ZERO_BYPASS_EN for the divide-by-zero scenario.
module tb_syn_gpu_div_agent;
   import syn_gpu_pkg::*;

   localparam mid_t OWN_MID     = mid_t'(MID_IDLE + 4'd1);
   localparam mid_t FOREIGN_MID = mid_t'(MID_IDLE + 4'd2);
   localparam int   TIMEOUT     = 64;

   logic        clk_ir;
   logic        rst_sync;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_dividend;
   logic [15:0] req_divisor;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_quotient;
   logic [15:0] rsp_remainder;
   logic        rsp_err;
   mid_t        div_req_mid;
   logic [31:0] div_req_data;
   logic        div_busy;
   mid_t        div_rsp_mid;
   logic [31:0] div_rsp_data;

   int checks = 0;
   int errors = 0;

   syn_gpu_div_agent #(.P_MID(OWN_MID), .P_TIMEOUT(TIMEOUT)) dut (
      .clk_ir        (clk_ir),
      .rst_sync      (rst_sync),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_dividend  (req_dividend),
      .req_divisor   (req_divisor),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_quotient  (rsp_quotient),
      .rsp_remainder (rsp_remainder),
      .rsp_err       (rsp_err),
      .div_req_mid   (div_req_mid),
      .div_req_data  (div_req_data),
      .div_busy      (div_busy),
      .div_rsp_mid   (div_rsp_mid),
      .div_rsp_data  (div_rsp_data)
   );

   initial begin
      clk_ir = 1'b0;
      forever #5 clk_ir = ~clk_ir;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk_ir);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Divider peer behaviour: {quotient, remainder}; divide-by-zero yields all-ones / dividend.
   function automatic logic [31:0] div_ref(input logic [15:0] a, input logic [15:0] b);
      if (b == 16'd0) return {16'hFFFF, a};
      return {a / b, a % b};
   endfunction

   task automatic send_rsp(input mid_t m, input logic [31:0] d);
      div_rsp_mid  = m;
      div_rsp_data = d;
      step();
      div_rsp_mid  = MID_IDLE;
      div_rsp_data = $urandom;
   endtask

   task automatic accept(input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("ready_wait", 32'(req_ready), 32'd1);
      req_dividend = a;
      req_divisor  = b;
      req_valid    = 1'b1;
      step();
      req_valid    = 1'b0;
      req_dividend = 16'($urandom);
      req_divisor  = 16'($urandom);
      chk("ready_drop", 32'(req_ready), 32'd0);
   endtask

   task automatic finish_rsp(input logic [15:0] q, input logic [15:0] r, input logic e);
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_q", 32'(rsp_quotient), 32'(q));
      chk("rsp_r", 32'(rsp_remainder), 32'(r));
      chk("rsp_err", 32'(rsp_err), 32'(e));
      rsp_ready = 1'b0;
      step();
      step();
      chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_hold_q", 32'(rsp_quotient), 32'(q));
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
      chk("ready_back", 32'(req_ready), 32'd1);
   endtask

   task automatic run_job(input logic [15:0] a, input logic [15:0] b, input int busy_cyc,
                          input int delay, input bit foreign);
      logic [31:0] res;
      res      = div_ref(a, b);
      div_busy = (busy_cyc > 0);
      accept(a, b);
      for (int i = 0; i < busy_cyc; i++) begin
         step();
         chk("busy_no_req", 32'(div_req_mid), 32'(MID_IDLE));
      end
      div_busy = 1'b0;
      step();
      chk("req_mid", 32'(div_req_mid), 32'(OWN_MID));
      chk("req_data", div_req_data, {a, b});
      step();
      chk("req_one_cycle", 32'(div_req_mid), 32'(MID_IDLE));
      for (int i = 0; i < delay; i++) begin
         if (foreign && i == 0) send_rsp(FOREIGN_MID, ~res);
         else step();
         chk("no_early_valid", 32'(rsp_valid), 32'd0);
      end
      send_rsp(OWN_MID, res);
      finish_rsp(res[31:16], res[15:0], 1'b0);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      rst_sync     = 1'b1;
      req_valid    = 1'b0;
      req_dividend = '0;
      req_divisor  = '0;
      rsp_ready    = 1'b0;
      div_busy     = 1'b0;
      div_rsp_mid  = MID_IDLE;
      div_rsp_data = '0;
      step();
      step();

      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_q", 32'(rsp_quotient), 32'd0);
      chk("rst_rsp_r", 32'(rsp_remainder), 32'd0);
      chk("rst_req_mid", 32'(div_req_mid), 32'(MID_IDLE));
      chk("rst_req_data", div_req_data, 32'd0);
      rst_sync = 1'b0;
      step();
      chk("idle_ready", 32'(req_ready), 32'd1);

      // 100/7 on a free divider, reply after 10 cycles
      run_job(16'd100, 16'd7, 0, 10, 1'b0);

      // divider busy for 20 cycles at issue
      run_job(16'($urandom), 16'($urandom_range(1, 65535)), 20, 4, 1'b0);

      // foreign MID response first, then own
      run_job(16'($urandom), 16'($urandom_range(1, 65535)), 0, 6, 1'b1);

      // randomised jobs
      for (int j = 0; j < 6; j++) begin
         ra = 16'($urandom);
         rb = 16'($urandom_range(1, 300));
         run_job(ra, rb, $urandom_range(0, 3), $urandom_range(1, 20), 1'($urandom_range(0, 1)));
      end

      // timeout: no response at all
      ra = 16'($urandom);
      accept(ra, 16'd9);
      step();
      chk("to_req_mid", 32'(div_req_mid), 32'(OWN_MID));
      for (int k = 1; k < TIMEOUT; k++) begin
         step();
         chk("to_no_valid", 32'(rsp_valid), 32'd0);
      end
      step();
      send_rsp(OWN_MID, div_ref(ra, 16'd9));
      finish_rsp(16'hFFFF, 16'hFFFF, 1'b1);
      send_rsp(OWN_MID, div_ref(ra, 16'd9));
      chk("late_rsp_idle_valid", 32'(rsp_valid), 32'd0);
      chk("late_rsp_idle_ready", 32'(req_ready), 32'd1);

      // divide by zero
`ifdef SYN_GPU_DIV_ZERO_BYPASS_EN
      accept(16'h1234, 16'h0000);
      chk("dz_no_req0", 32'(div_req_mid), 32'(MID_IDLE));
      step();
      chk("dz_no_req1", 32'(div_req_mid), 32'(MID_IDLE));
      finish_rsp(16'hFFFF, 16'h1234, 1'b1);
`else
      run_job(16'h1234, 16'h0000, 0, 5, 1'b0);
`endif

      // reset while waiting for the response
      ra = 16'($urandom);
      accept(ra, 16'd3);
      step();
      chk("rst_op_req_mid", 32'(div_req_mid), 32'(OWN_MID));
      step();
      rst_sync = 1'b1;
      step();
      chk("rst_op_ready", 32'(req_ready), 32'd0);
      chk("rst_op_valid", 32'(rsp_valid), 32'd0);
      chk("rst_op_q", 32'(rsp_quotient), 32'd0);
      chk("rst_op_r", 32'(rsp_remainder), 32'd0);
      chk("rst_op_err", 32'(rsp_err), 32'd0);
      chk("rst_op_mid", 32'(div_req_mid), 32'(MID_IDLE));
      chk("rst_op_data", div_req_data, 32'd0);
      rst_sync = 1'b0;
      send_rsp(OWN_MID, div_ref(ra, 16'd3));
      chk("stale_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("stale_rsp_ready", 32'(req_ready), 32'd1);
      run_job(16'($urandom), 16'($urandom_range(1, 65535)), 1, 3, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
